mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL take parameter MEM_LAT, default 2, memory access latency in cycles (legal range 1..15).
REQ-002 SHALL take parameter AW, default 32, address width.
REQ-003 SHALL take parameter DW, default 32, data width.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IReq  in  1  fetch stage requests an instruction read.
REQ-007 SHALL have port IAddr  in  AW  fetch address.
REQ-008 SHALL have port IRdata  out  DW  fetched instruction, valid when IReady=1.
REQ-009 SHALL have port IReady  out  1  one-cycle pulse, fetch access complete.
REQ-010 SHALL have port DReq  in  1  MEM stage requests a data access.
REQ-011 SHALL have port DWe  in  1  data access is a write.
REQ-012 SHALL have port DAddr  in  AW  data address.
REQ-013 SHALL have port DWdata  in  DW  store data.
REQ-014 SHALL have port DRdata  out  DW  load data, valid when DReady=1.
REQ-015 SHALL have port DReady  out  1  one-cycle pulse, data access complete.
REQ-016 SHALL have ports MemEn, MemWe (out, 1), MemAddr (out, AW), MemWdata (out, DW), MemRdata (in, DW): single-port unified memory.
REQ-017 SHALL have ports StallF, StallM  out  1  pipeline stall requests to the hazard unit.

Function
REQ-018 SHALL implement FSM states IDLE, IBUSY, DBUSY plus latency counter Cnt and last-grant bit LastD.
REQ-019 In IDLE with only DReq=1, SHALL move to DBUSY; with only IReq=1, to IBUSY; with neither, stay IDLE.
REQ-020 With IReq=DReq=1, SHALL grant data if LastD=0, instruction if LastD=1 (round-robin on conflict only).
REQ-021 On a grant SHALL latch the address, DWe and DWdata of the granted requester, set Cnt=1, and set LastD to 1 for data, 0 for instruction.
REQ-022 In IBUSY/DBUSY SHALL drive MemEn=1 and MemAddr/MemWe/MemWdata from the latched registers; MemWe=0 in IBUSY; all Mem* outputs 0 in IDLE.
REQ-023 SHALL increment Cnt each busy cycle; the busy cycle with Cnt==MEM_LAT is the completion cycle.
REQ-024 In the completion cycle SHALL assert IReady (IBUSY) or DReady (DBUSY) for exactly one cycle and pass MemRdata combinationally to IRdata/DRdata; both outputs 0 otherwise.
REQ-025 A request seen in IDLE at cycle T SHALL complete in cycle T+MEM_LAT.
REQ-026 After completion SHALL return to IDLE; the next grant occurs at the earliest in the following cycle (one idle cycle between accesses).
REQ-027 Requesters SHALL hold Req and operands stable until Ready; a Req drop mid-access SHALL NOT abort it, and Ready still pulses.
REQ-028 Requests arriving while busy SHALL be ignored until IDLE; no queuing.
REQ-029 SHALL drive StallF = IReq & ~IReady and StallM = DReq & ~DReady, combinationally.
REQ-030 A DWe=1 access SHALL still pulse DReady at completion; DRdata is don't-care and is driven 0.

Reset
REQ-031 While rst_n=0, SHALL hold state IDLE, Cnt=0, LastD=0, latched registers 0, and all outputs 0 except StallF/StallM, which follow REQ-029.
REQ-032 Reset asserted mid-access SHALL abort it immediately; no Ready pulse for the aborted access.

Structure
REQ-033 The state enum and the grant encoding SHALL live in shared package mem_arb_pkg.
REQ-034 The latency counter SHALL be sub-module lat_counter (clear, enable, terminal-count output at MEM_LAT).

Verification
REQ-035 With MEM_LAT=2, IReq=1, IAddr=0x40 at cycle 0 -> MemEn=1, MemAddr=0x40 in cycles 1-2; IReady=1 and IRdata=MemRdata in cycle 2; StallF=1 in cycles 0-1.
REQ-036 With IReq=DReq=1 from reset, DAddr=0x100 -> data granted first (DReady cycle 2), instruction granted cycle 3, IReady cycle 5; a repeat conflict then grants data.
REQ-037 With DReq=1, DWe=1, DAddr=0x20, DWdata=0xDEADBEEF -> MemWe=1, MemWdata=0xDEADBEEF in cycles 1-2; DReady=1 cycle 2; DRdata=0.
REQ-038 With rst_n pulsed low in cycle 1 of an instruction access -> MemEn=0 at once, no IReady pulse, and the next IReq restarts from IDLE with full latency.
REQ-039 With MEM_LAT=1 and back-to-back IReq -> IReady every second cycle; with MEM_LAT=4 -> IReady 4 cycles after grant.
REQ-040 With DReq dropped in cycle 1 of a DBUSY access -> access completes and DReady=1 in cycle 2 regardless.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding,
// grant encoding and the round-robin grant decision.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Data wins unless both request and data was the last one served.
  function automatic grant_e pickGrant(input logic iReq, input logic dReq, input logic lastD);
    if (dReq && !(iReq && lastD)) return GRANT_D;
    return GRANT_I;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Memory access latency counter: loads 1 when an access starts, counts each
// busy cycle and flags the terminal count MAX.
module lat_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (load_i) cnt_d = CNT_W'(1);
    else if (en_i)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and MEM stages onto one single-port memory with a
// fixed access latency, round-robin on simultaneous requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic [DW-1:0] IRdata,
  output logic          IReady,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic [DW-1:0] DRdata,
  output logic          DReady,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  output logic          StallF,
  output logic          StallM
);

  arb_state_e    state_q;
  logic          lastD_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;

  logic   busy, start, tc, done;
  grant_e grant;

  assign busy  = (state_q != IDLE);
  assign start = (state_q == IDLE) && (IReq || DReq);
  assign done  = busy && tc;
  assign grant = pickGrant(IReq, DReq, lastD_q);

  lat_counter #(.MAX(MEM_LAT)) uLatCounter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(done),
    .load_i (start),
    .en_i   (busy && !tc),
    .tc_o   (tc)
  );

  // Requests seen while busy are dropped; the requester keeps asserting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lastD_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (grant == GRANT_D) begin
              state_q <= DBUSY;
              lastD_q <= 1'b1;
              addr_q  <= DAddr;
              we_q    <= DWe;
              wdata_q <= DWdata;
            end else begin
              state_q <= IBUSY;
              lastD_q <= 1'b0;
              addr_q  <= IAddr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
        end
        IBUSY, DBUSY: begin
          if (tc) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MemEn    = busy;
  assign MemWe    = (state_q == DBUSY) && we_q;
  assign MemAddr  = busy ? addr_q : '0;
  assign MemWdata = (state_q == DBUSY) ? wdata_q : '0;

  assign IReady = (state_q == IBUSY) && done;
  assign DReady = (state_q == DBUSY) && done;
  assign IRdata = IReady ? MemRdata : '0;
  assign DRdata = (DReady && !we_q) ? MemRdata : '0;

  assign StallF = IReq && !IReady;
  assign StallM = DReq && !DReady;

endmodule
